// File: rtl/exe_seq.sv
// exe_seq: multi-cycle execute sequencer driving the shared ALU
// Ports: in_* handshake, exe control/operands, out_* result + redirect
module exe_seq #(
   parameter int          WIDTH   = 32,
   parameter logic [3:0]  ALU_ADD = 4'b0000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_class,
   input  logic [3:0]       in_alu_op,
   input  logic [2:0]       in_br_op,
   input  logic [WIDTH-1:0] in_pc,
   input  logic [WIDTH-1:0] in_imm,
   input  logic [WIDTH-1:0] in_rd1,
   input  logic [WIDTH-1:0] in_rd2,
   input  logic             flush,
   output logic [1:0]       ALUa,
   output logic [1:0]       ALUb,
   output logic [3:0]       alu_cntr,
   output logic [2:0]       branch_cntr,
   output logic [WIDTH-1:0] x_pc,
   output logic [WIDTH-1:0] x_imm,
   output logic [WIDTH-1:0] x_rd1,
   output logic [WIDTH-1:0] x_rd2,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             pcbranch,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_rd_we,
   output logic             out_redirect,
   output logic [WIDTH-1:0] out_target
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_EXEC = 3'd1;
   localparam logic [2:0] S_LINK = 3'd2;
   localparam logic [2:0] S_TGT  = 3'd3;
   localparam logic [2:0] S_HOLD = 3'd4;

   localparam logic [2:0] C_RR     = 3'b000;
   localparam logic [2:0] C_RI     = 3'b001;
   localparam logic [2:0] C_SHIFT  = 3'b010;
   localparam logic [2:0] C_LUI    = 3'b011;
   localparam logic [2:0] C_AUIPC  = 3'b100;
   localparam logic [2:0] C_BRANCH = 3'b101;
   localparam logic [2:0] C_JAL    = 3'b110;
   localparam logic [2:0] C_JALR   = 3'b111;

   logic [2:0] state;
   logic [2:0] cls;
   logic [3:0] op;
   logic [2:0] br;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_HOLD);

   // Operand-select encoding: ALUa 01 zero, 10 pc, 11 rd1;
   // ALUb 00 rd2, 01 rd2&1F, 10 imm, 11 const 4.
   always_comb begin
      ALUa        = 2'b11;
      ALUb        = 2'b00;
      alu_cntr    = ALU_ADD;
      branch_cntr = 3'b000;
      unique case (1'b1)
         (state == S_EXEC): begin
            unique case (cls)
               C_RR:     alu_cntr = op;
               C_RI: begin
                  ALUb     = 2'b10;
                  alu_cntr = op;
               end
               C_SHIFT: begin
                  ALUb     = 2'b01;
                  alu_cntr = op;
               end
               C_LUI: begin
                  ALUa = 2'b01;
                  ALUb = 2'b10;
               end
               C_AUIPC, C_JAL: begin
                  ALUa = 2'b10;
                  ALUb = 2'b10;
               end
               C_BRANCH: begin
                  alu_cntr    = op;
                  branch_cntr = br;
               end
               C_JALR:   ALUb = 2'b10;
               default: ;
            endcase
         end
         (state == S_TGT): begin
            ALUa = 2'b10;
            ALUb = 2'b10;
         end
         (state == S_LINK): begin
            ALUa = 2'b10;
            ALUb = 2'b11;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cls          <= '0;
         op           <= '0;
         br           <= '0;
         x_pc         <= '0;
         x_imm        <= '0;
         x_rd1        <= '0;
         x_rd2        <= '0;
         out_result   <= '0;
         out_target   <= '0;
         out_rd_we    <= 1'b0;
         out_redirect <= 1'b0;
      end else if (flush) begin
         state        <= S_IDLE;
         out_rd_we    <= 1'b0;
         out_redirect <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  cls          <= in_class;
                  op           <= in_alu_op;
                  br           <= in_br_op;
                  x_pc         <= in_pc;
                  x_imm        <= in_imm;
                  x_rd1        <= in_rd1;
                  x_rd2        <= in_rd2;
                  out_rd_we    <= 1'b0;
                  out_redirect <= 1'b0;
                  state        <= S_EXEC;
               end
            end
            S_EXEC: begin
               case (cls)
                  C_BRANCH:
                     state <= pcbranch ? S_TGT : S_HOLD;
                  C_JAL: begin
                     out_target <= alu_result;
                     state      <= S_LINK;
                  end
                  C_JALR: begin
                     // jalr target has bit 0 forced clear
                     out_target <= {alu_result[WIDTH-1:1], 1'b0};
                     state      <= S_LINK;
                  end
                  default: begin
                     out_result <= alu_result;
                     out_rd_we  <= 1'b1;
                     state      <= S_HOLD;
                  end
               endcase
            end
            S_TGT: begin
               out_target   <= alu_result;
               out_redirect <= 1'b1;
               state        <= S_HOLD;
            end
            S_LINK: begin
               out_result   <= alu_result;
               out_rd_we    <= 1'b1;
               out_redirect <= 1'b1;
               state        <= S_HOLD;
            end
            S_HOLD: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exe_seq.sv
// tb_exe_seq: directed + random checks of exe_seq against a
// behavioural exe model and an instruction-level reference
module tb_exe_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [2:0]  in_class;
   logic [3:0]  in_alu_op;
   logic [2:0]  in_br_op;
   logic [31:0] in_pc, in_imm, in_rd1, in_rd2;
   logic        flush;
   logic [1:0]  ALUa, ALUb;
   logic [3:0]  alu_cntr;
   logic [2:0]  branch_cntr;
   logic [31:0] x_pc, x_imm, x_rd1, x_rd2;
   logic [31:0] alu_result;
   logic        pcbranch;
   logic        out_valid, out_ready;
   logic [31:0] out_result, out_target;
   logic        out_rd_we, out_redirect;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   exe_seq #(.WIDTH(32), .ALU_ADD(4'b0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_class(in_class), .in_alu_op(in_alu_op),
      .in_br_op(in_br_op),
      .in_pc(in_pc), .in_imm(in_imm),
      .in_rd1(in_rd1), .in_rd2(in_rd2),
      .flush(flush),
      .ALUa(ALUa), .ALUb(ALUb),
      .alu_cntr(alu_cntr), .branch_cntr(branch_cntr),
      .x_pc(x_pc), .x_imm(x_imm),
      .x_rd1(x_rd1), .x_rd2(x_rd2),
      .alu_result(alu_result), .pcbranch(pcbranch),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_rd_we(out_rd_we),
      .out_redirect(out_redirect), .out_target(out_target)
   );

   function automatic logic [31:0] alu(
      input logic [3:0] o, input logic [31:0] a, b);
      case (o)
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << b[4:0];
         4'd6:    return a >> b[4:0];
         4'd7:    return $signed(a) >>> b[4:0];
         4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return a + b;
      endcase
   endfunction

   function automatic logic cmp(
      input logic [2:0] bo, input logic [31:0] a, b);
      case (bo)
         3'd1:    return a == b;
         3'd2:    return a != b;
         3'd3:    return $signed(a) < $signed(b);
         3'd4:    return $signed(a) >= $signed(b);
         default: return 1'b0;
      endcase
   endfunction

   // execute-unit model
   logic [31:0] ea, eb;
   always_comb begin
      ea = 32'd0;
      eb = 32'd0;
      case (ALUa)
         2'b10:   ea = x_pc;
         2'b11:   ea = x_rd1;
         default: ea = 32'd0;
      endcase
      case (ALUb)
         2'b00:   eb = x_rd2;
         2'b01:   eb = x_rd2 & 32'h1F;
         2'b10:   eb = x_imm;
         default: eb = 32'd4;
      endcase
      alu_result = alu(alu_cntr, ea, eb);
      pcbranch   = cmp(branch_cntr, ea, eb);
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs, exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   // instruction-level reference
   task automatic ref_model(
      input  logic [2:0] c, input logic [3:0] o,
      input  logic [2:0] b,
      input  logic [31:0] pc, imm, r1, r2,
      output int lat, output logic [31:0] res, tgt,
      output logic we, rdr);
      lat = 2; res = 0; tgt = 0; we = 1; rdr = 0;
      case (c)
         3'd0: res = alu(o, r1, r2);
         3'd1: res = alu(o, r1, imm);
         3'd2: res = alu(o, r1, r2 & 32'h1F);
         3'd3: res = imm;
         3'd4: res = pc + imm;
         3'd5: begin
            we  = 0;
            rdr = cmp(b, r1, r2);
            lat = rdr ? 3 : 2;
            tgt = pc + imm;
         end
         3'd6: begin
            lat = 3; rdr = 1;
            tgt = pc + imm;
            res = pc + 32'd4;
         end
         default: begin
            lat = 3; rdr = 1;
            tgt = (r1 + imm) & 32'hFFFF_FFFE;
            res = pc + 32'd4;
         end
      endcase
   endtask

   task automatic drive(
      input logic [2:0] c, input logic [3:0] o,
      input logic [2:0] b,
      input logic [31:0] pc, imm, r1, r2);
      in_class = c; in_alu_op = o; in_br_op = b;
      in_pc = pc; in_imm = imm; in_rd1 = r1; in_rd2 = r2;
   endtask

   task automatic run(
      input logic [2:0] c, input logic [3:0] o,
      input logic [2:0] b,
      input logic [31:0] pc, imm, r1, r2,
      input int hold);
      int lat, elat;
      logic [31:0] eres, etgt;
      logic ewe, erdr;
      ref_model(c, o, b, pc, imm, r1, r2,
                elat, eres, etgt, ewe, erdr);
      @(negedge clk);
      chk("idle_ready", 32'(in_ready), 32'd1);
      drive(c, o, b, pc, imm, r1, r2);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(elat));
      chk("valid", 32'(out_valid), 32'd1);
      chk("rd_we", 32'(out_rd_we), 32'(ewe));
      chk("redirect", 32'(out_redirect), 32'(erdr));
      if (ewe) chk("result", out_result, eres);
      if (erdr) chk("target", out_target, etgt);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         drive(3'($urandom), 4'($urandom), 3'($urandom),
               $urandom, $urandom, $urandom, $urandom);
         @(negedge clk);
         chk("hold_ready", 32'(in_ready), 32'd0);
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_we", 32'(out_rd_we), 32'(ewe));
         chk("hold_rdr", 32'(out_redirect), 32'(erdr));
         if (ewe) chk("hold_res", out_result, eres);
         if (erdr) chk("hold_tgt", out_target, etgt);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("release_valid", 32'(out_valid), 32'd0);
      chk("release_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
      out_ready = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_result", out_result, 32'd0);
      chk("rst_target", out_target, 32'd0);
      chk("rst_rdr", 32'(out_redirect), 32'd0);
      rst_n = 1'b1;

      // RR ADD
      run(3'd0, 4'd0, 3'd0, 32'h0, 32'h0, 32'd5, 32'd7, 0);
      // BEQ taken / not taken
      run(3'd5, 4'd1, 3'd1, 32'h100, 32'h20, 32'd3, 32'd3, 0);
      run(3'd5, 4'd1, 3'd1, 32'h100, 32'h20, 32'd3, 32'd4, 0);
      // JALR, JAL wrap
      run(3'd7, 4'd0, 3'd0, 32'h40, 32'd4, 32'h203, 32'd0, 0);
      run(3'd6, 4'd0, 3'd0, 32'hFFFF_FFFC, 32'd8, 0, 0, 0);
      // long hold with in_valid asserted
      run(3'd1, 4'd4, 3'd0, 32'h0, 32'h0F0F, 32'hFF00, 0, 5);

      // flush beats in_valid in IDLE
      @(negedge clk);
      drive(3'd0, 4'd0, 3'd0, 0, 0, 1, 1);
      in_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      chk("fidle_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      chk("fidle_valid", 32'(out_valid), 32'd0);

      // flush in TGT
      drive(3'd5, 4'd1, 3'd1, 32'h100, 32'h20, 32'd9, 32'd9);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("ftgt_ready", 32'(in_ready), 32'd1);
      chk("ftgt_valid", 32'(out_valid), 32'd0);
      chk("ftgt_rdr", 32'(out_redirect), 32'd0);
      chk("ftgt_we", 32'(out_rd_we), 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("ftgt_after", 32'(out_valid), 32'd0);
      end

      // async reset in LINK
      drive(3'd6, 4'd0, 3'd0, 32'h500, 32'h40, 0, 0);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rlink_ready", 32'(in_ready), 32'd1);
      chk("rlink_valid", 32'(out_valid), 32'd0);
      chk("rlink_tgt", out_target, 32'd0);
      chk("rlink_res", out_result, 32'd0);
      chk("rlink_rdr", 32'(out_redirect), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("rlink_after", 32'(out_valid), 32'd0);
      end

      // random instructions
      for (int n = 0; n < 60; n++) begin
         logic [31:0] r1, r2;
         r1 = $urandom;
         r2 = ($urandom_range(0, 1) == 1) ? r1 : $urandom;
         run(3'($urandom_range(0, 7)),
             4'($urandom_range(0, 8)),
             3'($urandom_range(1, 4)),
             $urandom, $urandom, r1, r2,
             $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
